// File: rtl/peak_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | peak_resolve                                                               |
// | Collects a frame of peak records and resolves each record's phase.         |
// | It also IIR-averages each magnitude, then emits the frame as a stream.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module peak_resolve #(
    parameter int NPEAKS      = 4,
    parameter int ALPHA_SHIFT = 2
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          sink_sop,
    input  logic                                          sink_eop,
    input  logic                                          sink_valid,
    input  logic signed [31:0]                            sink_freq,
    input  logic signed [31:0]                            sink_mag,
    input  logic signed [31:0]                            sink_phaseA,
    input  logic signed [31:0]                            sink_phaseB,
    input  logic                                          source_ready,
    output logic                                          source_valid,
    output logic                                          source_sop,
    output logic                                          source_eop,
    output logic [((NPEAKS > 1) ? $clog2(NPEAKS) : 1)-1:0] source_idx,
    output logic signed [31:0]                            source_freq,
    output logic signed [31:0]                            source_mag,
    output logic signed [31:0]                            source_phase,
    output logic signed [31:0]                            source_dphase,
    output logic                                          overrun,
    output logic                                          frame_err
);
    localparam int c_iw = (NPEAKS > 1) ? $clog2(NPEAKS) : 1;
    localparam int c_cw = $clog2(NPEAKS + 1);
    localparam logic [c_iw-1:0] c_last_idx = c_iw'(NPEAKS - 1);
    localparam logic [c_cw-1:0] c_last_cnt = c_cw'(NPEAKS - 1);
    localparam logic [c_cw-1:0] c_full_cnt = c_cw'(NPEAKS);
    localparam logic signed [32:0] c_half_turn = 33'sd46080;
    localparam logic signed [32:0] c_full_turn = 33'sd92160;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PROCESS = 2'd2,
        S_EMIT    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [c_cw-1:0]     coll_idx_q, coll_idx_d;
    logic [c_iw-1:0]     proc_idx_q, proc_idx_d;
    logic [c_iw-1:0]     emit_idx_q, emit_idx_d;
    logic                hist_valid_q, hist_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;
    logic signed [31:0]  rec_freq_q  [NPEAKS], rec_freq_d  [NPEAKS];
    logic signed [31:0]  rec_mag_q   [NPEAKS], rec_mag_d   [NPEAKS];
    logic signed [31:0]  rec_pa_q    [NPEAKS], rec_pa_d    [NPEAKS];
    logic signed [31:0]  rec_pb_q    [NPEAKS], rec_pb_d    [NPEAKS];
    logic signed [31:0]  res_phase_q [NPEAKS], res_phase_d [NPEAKS];
    logic signed [31:0]  res_dphase_q[NPEAKS], res_dphase_d[NPEAKS];
    logic signed [31:0]  res_mag_q   [NPEAKS], res_mag_d   [NPEAKS];
    logic signed [31:0]  hist_phase_q[NPEAKS], hist_phase_d[NPEAKS];
    logic signed [31:0]  hist_avg_q  [NPEAKS], hist_avg_d  [NPEAKS];

    logic                store;
    logic [c_cw-1:0]     beat_idx;
    logic signed [32:0]  diff_a, diff_b;
    logic signed [31:0]  mag_step;
    logic signed [31:0]  sel_phase, sel_dphase, sel_avg;
    logic                emit;

    // Phase difference folded into one turn (360 deg = 92160 in 8-bit fixed point).
    function automatic logic signed [32:0] wrap_diff(input logic signed [31:0] x,
                                                     input logic signed [31:0] prev);
        logic signed [32:0] d;
        d = {x[31], x} - {prev[31], prev};
        if (d > c_half_turn)
            d = d - c_full_turn;
        else if (d < -c_half_turn)
            d = d + c_full_turn;
        return d;
    endfunction

    function automatic logic [32:0] abs33(input logic signed [32:0] d);
        return (d < 0) ? 33'(-d) : 33'(d);
    endfunction

    always_comb begin
        diff_a     = wrap_diff(rec_pa_q[proc_idx_q], hist_phase_q[proc_idx_q]);
        diff_b     = wrap_diff(rec_pb_q[proc_idx_q], hist_phase_q[proc_idx_q]);
        mag_step   = rec_mag_q[proc_idx_q] - hist_avg_q[proc_idx_q];
        sel_phase  = rec_pa_q[proc_idx_q];
        sel_dphase = '0;
        sel_avg    = rec_mag_q[proc_idx_q];
        if (hist_valid_q) begin
            sel_avg = hist_avg_q[proc_idx_q] + (mag_step >>> ALPHA_SHIFT);
            if (abs33(diff_a) <= abs33(diff_b)) begin
                sel_dphase = diff_a[31:0];
            end else begin
                sel_phase  = rec_pb_q[proc_idx_q];
                sel_dphase = diff_b[31:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        coll_idx_d   = coll_idx_q;
        proc_idx_d   = proc_idx_q;
        emit_idx_d   = emit_idx_q;
        hist_valid_d = hist_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        rec_freq_d   = rec_freq_q;
        rec_mag_d    = rec_mag_q;
        rec_pa_d     = rec_pa_q;
        rec_pb_d     = rec_pb_q;
        res_phase_d  = res_phase_q;
        res_dphase_d = res_dphase_q;
        res_mag_d    = res_mag_q;
        hist_phase_d = hist_phase_q;
        hist_avg_d   = hist_avg_q;
        store        = 1'b0;
        beat_idx     = '0;

        case (state_q)
            S_IDLE: begin
                if (sink_valid && sink_sop)
                    store = 1'b1;
            end
            S_COLLECT: begin
                if (sink_valid) begin
                    if (sink_sop) begin
                        frame_err_d = 1'b1;
                        store       = 1'b1;
                    end else if (coll_idx_q == c_full_cnt) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        store    = 1'b1;
                        beat_idx = coll_idx_q;
                    end
                end
            end
            S_PROCESS: begin
                overrun_d                = sink_valid && sink_sop;
                res_phase_d[proc_idx_q]  = sel_phase;
                res_dphase_d[proc_idx_q] = sel_dphase;
                res_mag_d[proc_idx_q]    = sel_avg;
                hist_phase_d[proc_idx_q] = sel_phase;
                hist_avg_d[proc_idx_q]   = sel_avg;
                if (proc_idx_q == c_last_idx) begin
                    hist_valid_d = 1'b1;
                    emit_idx_d   = '0;
                    state_d      = S_EMIT;
                end else begin
                    proc_idx_d = proc_idx_q + 1'b1;
                end
            end
            S_EMIT: begin
                overrun_d = sink_valid && sink_sop;
                if (source_ready) begin
                    if (emit_idx_q == c_last_idx)
                        state_d = S_IDLE;
                    else
                        emit_idx_d = emit_idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A stored beat either completes the frame, breaks it, or extends it.
        if (store) begin
            rec_freq_d[beat_idx[c_iw-1:0]] = sink_freq;
            rec_mag_d[beat_idx[c_iw-1:0]]  = sink_mag;
            rec_pa_d[beat_idx[c_iw-1:0]]   = sink_phaseA;
            rec_pb_d[beat_idx[c_iw-1:0]]   = sink_phaseB;
            if (sink_eop) begin
                if (beat_idx == c_last_cnt) begin
                    proc_idx_d = '0;
                    state_d    = S_PROCESS;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end else begin
                coll_idx_d = beat_idx + 1'b1;
                state_d    = S_COLLECT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            coll_idx_q   <= '0;
            proc_idx_q   <= '0;
            emit_idx_q   <= '0;
            hist_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            rec_freq_q   <= '{default: '0};
            rec_mag_q    <= '{default: '0};
            rec_pa_q     <= '{default: '0};
            rec_pb_q     <= '{default: '0};
            res_phase_q  <= '{default: '0};
            res_dphase_q <= '{default: '0};
            res_mag_q    <= '{default: '0};
            hist_phase_q <= '{default: '0};
            hist_avg_q   <= '{default: '0};
        end else begin
            state_q      <= state_d;
            coll_idx_q   <= coll_idx_d;
            proc_idx_q   <= proc_idx_d;
            emit_idx_q   <= emit_idx_d;
            hist_valid_q <= hist_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            rec_freq_q   <= rec_freq_d;
            rec_mag_q    <= rec_mag_d;
            rec_pa_q     <= rec_pa_d;
            rec_pb_q     <= rec_pb_d;
            res_phase_q  <= res_phase_d;
            res_dphase_q <= res_dphase_d;
            res_mag_q    <= res_mag_d;
            hist_phase_q <= hist_phase_d;
            hist_avg_q   <= hist_avg_d;
        end
    end

    always_comb begin
        emit          = (state_q == S_EMIT);
        source_valid  = emit;
        source_idx    = emit ? emit_idx_q : '0;
        source_sop    = emit && (emit_idx_q == '0);
        source_eop    = emit && (emit_idx_q == c_last_idx);
        source_freq   = emit ? rec_freq_q[emit_idx_q]   : '0;
        source_mag    = emit ? res_mag_q[emit_idx_q]    : '0;
        source_phase  = emit ? res_phase_q[emit_idx_q]  : '0;
        source_dphase = emit ? res_dphase_q[emit_idx_q] : '0;
        overrun       = overrun_q;
        frame_err     = frame_err_q;
    end
endmodule
`default_nettype wire
